// File: rtl/lbm_sequencer.sv
// rtl/lbm_sequencer.sv - D2Q9 lattice-Boltzmann timestep sequencer and lattice BRAM port mux
//
// Runs SETUP -> (WAITING -> COLLISION -> STREAMING)* and owns the lattice BRAM
// write port. The collision pass streams one cell per cycle into a collider
// with a fixed latency. Run, single-step and restart controls are provided,
// along with a step counter and a sticky collider-timing error flag.
//
// Optional feature: define LBM_BOUNCEBACK_EN to add obstacle_in. Obstacle
// cells are written with their directions reflected instead of taking the
// collider result.
//
// Ports:
//   clk_in, rst_n_in          clock, asynchronous active-low reset
//   run_in, step_in           free-run level, single-step pulse
//   restart_in                re-run setup (honoured only in WAITING)
//   phase_out                 0 SETUP, 1 COLLISION, 2 STREAMING, 3 WAITING
//   setup_start_out           start pulse to setup engine
//   setup_done_in, setup_*    setup engine handshake and write port
//   stream_start_out          start pulse to streaming engine
//   stream_done_in, stream_*  streaming engine handshake and write port
//   rd_addr_out, rd_data_in   BRAM read port used during COLLISION
//   obstacle_in               (LBM_BOUNCEBACK_EN) obstacle flag aligned with rd_data_in
//   coll_valid_out            rd_data_in holds a real cell this cycle
//   coll_valid_in, coll_data_in  collider result
//   wr_addr_out, wr_data_out, wr_en_out  registered BRAM write port
//   step_count_out            completed timesteps since setup
//   err_out                   sticky collider-timing error
module lbm_sequencer #(
  parameter int HPIXELS     = 160,
  parameter int VPIXELS     = 120,
  parameter int DW          = 8,
  parameter int READ_LAT    = 2,
  parameter int COLL_LAT    = 3,
  parameter int WAIT_CYCLES = 1024,
  localparam int DEPTH      = HPIXELS * VPIXELS,
  localparam int AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW         = 9 * DW
) (
  input  logic          clk_in,
  input  logic          rst_n_in,
  input  logic          run_in,
  input  logic          step_in,
  input  logic          restart_in,
  output logic [1:0]    phase_out,
  output logic          setup_start_out,
  input  logic          setup_done_in,
  input  logic [AW-1:0] setup_addr_in,
  input  logic [CW-1:0] setup_data_in,
  input  logic          setup_we_in,
  output logic          stream_start_out,
  input  logic          stream_done_in,
  input  logic [AW-1:0] stream_addr_in,
  input  logic [CW-1:0] stream_data_in,
  input  logic          stream_we_in,
  output logic [AW-1:0] rd_addr_out,
  input  logic [CW-1:0] rd_data_in,
`ifdef LBM_BOUNCEBACK_EN
  input  logic          obstacle_in,
`endif
  output logic          coll_valid_out,
  input  logic          coll_valid_in,
  input  logic [CW-1:0] coll_data_in,
  output logic [AW-1:0] wr_addr_out,
  output logic [CW-1:0] wr_data_out,
  output logic          wr_en_out,
  output logic [31:0]   step_count_out,
  output logic          err_out
);

  // Total read + collider latency: the distance between issuing a cell and
  // its result being due back.
  localparam int PL        = READ_LAT + COLL_LAT;
  localparam int PASS_LAST = DEPTH + PL;
  localparam int PCW       = $clog2(PASS_LAST + 1);
  localparam int WCW       = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

  typedef enum logic [1:0] {
    PH_SETUP     = 2'd0,
    PH_COLLISION = 2'd1,
    PH_STREAMING = 2'd2,
    PH_WAITING   = 2'd3
  } phase_t;

  phase_t state, state_next;

  logic           booted;
  logic           pending;
  logic [WCW-1:0] wait_cnt;
  logic           wait_expired;
  logic [PCW-1:0] pass_cnt;
  logic           pass_end;
  logic           issue;
  logic [PL-1:0]  tag_pipe;
  logic [AW-1:0]  addr_pipe [PL];
  logic           exp_tag;
  logic [AW-1:0]  exp_addr;
  logic [CW-1:0]  cell_result;

  logic go_setup, go_coll, go_stream, go_wait;

  // The counter saturates at WAIT_CYCLES, so equality is the expiry test
  // (WAIT_CYCLES = 0 is expired from the first WAITING cycle).
  assign wait_expired = (wait_cnt == WCW'(WAIT_CYCLES));
  assign pass_end     = (pass_cnt == PCW'(PASS_LAST));

  assign phase_out      = state;
  assign coll_valid_out = tag_pipe[READ_LAT-1];
  assign exp_tag        = tag_pipe[PL-1];
  assign exp_addr       = addr_pipe[PL-1];

  // ---------------------------------------------------------------------
  // Phase FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state <= PH_SETUP;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    go_setup   = 1'b0;
    go_coll    = 1'b0;
    go_stream  = 1'b0;
    go_wait    = 1'b0;
    case (state)
      PH_SETUP: begin
        if (setup_done_in) begin
          state_next = PH_WAITING;
          go_wait    = 1'b1;
        end
      end
      PH_WAITING: begin
        // Restart takes priority over starting the next timestep.
        if (restart_in) begin
          state_next = PH_SETUP;
          go_setup   = 1'b1;
        end else if (wait_expired && (run_in || pending)) begin
          state_next = PH_COLLISION;
          go_coll    = 1'b1;
        end
      end
      PH_COLLISION: begin
        if (pass_end) begin
          state_next = PH_STREAMING;
          go_stream  = 1'b1;
        end
      end
      PH_STREAMING: begin
        if (stream_done_in) begin
          state_next = PH_WAITING;
          go_wait    = 1'b1;
        end
      end
      default: state_next = PH_SETUP;
    endcase
  end

  // ---------------------------------------------------------------------
  // Control: start pulses, pending step, wait counter, step counter, error
  // ---------------------------------------------------------------------
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      booted           <= 1'b0;
      setup_start_out  <= 1'b0;
      stream_start_out <= 1'b0;
      pending          <= 1'b0;
      wait_cnt         <= '0;
      step_count_out   <= '0;
      err_out          <= 1'b0;
    end else begin
      booted           <= 1'b1;
      // The very first cycle out of reset kicks the setup engine.
      setup_start_out  <= go_setup | ~booted;
      stream_start_out <= go_stream;

      // Launching a timestep consumes the request; a pulse landing on the
      // launch cycle collapses into the one being served.
      if (go_coll) begin
        pending <= 1'b0;
      end else if (step_in) begin
        pending <= 1'b1;
      end

      if (go_wait) begin
        wait_cnt <= '0;
      end else if (state == PH_WAITING && !wait_expired) begin
        wait_cnt <= wait_cnt + WCW'(1);
      end

      if (go_setup) begin
        step_count_out <= '0;
      end else if (state == PH_STREAMING && stream_done_in) begin
        step_count_out <= step_count_out + 32'd1;
      end

      // A result must arrive exactly in the slot its issue tag predicts.
      if (coll_valid_in != exp_tag) begin
        err_out <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Collision issue and tag/address delay lines
  // ---------------------------------------------------------------------
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      rd_addr_out <= '0;
      issue       <= 1'b0;
      pass_cnt    <= '0;
      tag_pipe    <= '0;
      for (int i = 0; i < PL; i++) begin
        addr_pipe[i] <= '0;
      end
    end else begin
      if (go_coll) begin
        rd_addr_out <= '0;
        issue       <= 1'b1;
        pass_cnt    <= '0;
      end else if (state == PH_COLLISION) begin
        pass_cnt <= pass_cnt + PCW'(1);
        if (issue) begin
          if (rd_addr_out == AW'(DEPTH - 1)) begin
            issue <= 1'b0;
          end else begin
            rd_addr_out <= rd_addr_out + AW'(1);
          end
        end
      end

      tag_pipe[0]  <= issue;
      addr_pipe[0] <= rd_addr_out;
      for (int i = 1; i < PL; i++) begin
        tag_pipe[i]  <= tag_pipe[i-1];
        addr_pipe[i] <= addr_pipe[i-1];
      end
    end
  end

`ifdef LBM_BOUNCEBACK_EN
  // Obstacle flag and the raw cell travel alongside the collider so they
  // line up with the expected result slot.
  logic [COLL_LAT-1:0] obs_pipe;
  logic [CW-1:0]       rdd_pipe [COLL_LAT];

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      obs_pipe <= '0;
      for (int i = 0; i < COLL_LAT; i++) begin
        rdd_pipe[i] <= '0;
      end
    end else begin
      obs_pipe[0] <= obstacle_in & coll_valid_out;
      rdd_pipe[0] <= rd_data_in;
      for (int i = 1; i < COLL_LAT; i++) begin
        obs_pipe[i] <= obs_pipe[i-1];
        rdd_pipe[i] <= rdd_pipe[i-1];
      end
    end
  end

  // Reflect each moving population to the opposite direction; the rest
  // population (slot 0) stays put.
  function automatic logic [CW-1:0] bounce(input logic [CW-1:0] d);
    logic [CW-1:0] r;
    r = d;
    for (int i = 1; i <= 8; i++) begin
      r[(((i + 3) % 8) + 1)*DW +: DW] = d[i*DW +: DW];
    end
    return r;
  endfunction

  assign cell_result = obs_pipe[COLL_LAT-1] ? bounce(rdd_pipe[COLL_LAT-1]) : coll_data_in;
`else
  // rd_data_in feeds the collider directly outside this block.
  logic unused_rd_data;
  assign unused_rd_data = ^rd_data_in;
  assign cell_result    = coll_data_in;
`endif

  // ---------------------------------------------------------------------
  // Registered BRAM write mux
  // ---------------------------------------------------------------------
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      wr_addr_out <= '0;
      wr_data_out <= '0;
      wr_en_out   <= 1'b0;
    end else begin
      wr_en_out <= 1'b0;
      case (state)
        PH_SETUP: begin
          if (!setup_done_in) begin
            wr_addr_out <= setup_addr_in;
            wr_data_out <= setup_data_in;
            wr_en_out   <= setup_we_in;
          end
        end
        PH_STREAMING: begin
          if (!stream_done_in) begin
            wr_addr_out <= stream_addr_in;
            wr_data_out <= stream_data_in;
            wr_en_out   <= stream_we_in;
          end
        end
        PH_COLLISION: begin
          // Writes follow the issue tag even if the collider is mistimed.
          if (exp_tag) begin
            wr_addr_out <= exp_addr;
            wr_data_out <= cell_result;
            wr_en_out   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lbm_sequencer.sv
// tb/tb_lbm_sequencer.sv - randomized self-checking bench for lbm_sequencer
module tb_lbm_sequencer;
  localparam int HP       = 4;
  localparam int VP       = 2;
  localparam int DW       = 8;
  localparam int RL       = 2;
  localparam int CL       = 3;
  localparam int WC       = 4;
  localparam int DEPTH    = HP * VP;
  localparam int AW       = $clog2(DEPTH);
  localparam int CDW      = 9 * DW;
  localparam int PASS_LEN = DEPTH + RL + CL + 1;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           run, step, restart;
  logic [1:0]     phase;
  logic           setup_start, setup_done, setup_we;
  logic [AW-1:0]  setup_addr;
  logic [CDW-1:0] setup_data;
  logic           stream_start, stream_done, stream_we;
  logic [AW-1:0]  stream_addr;
  logic [CDW-1:0] stream_data;
  logic [AW-1:0]  rd_addr;
  logic [CDW-1:0] rd_data;
  logic           coll_valid_out, coll_valid_in;
  logic [CDW-1:0] coll_data;
  logic [AW-1:0]  wr_addr;
  logic [CDW-1:0] wr_data;
  logic           wr_en;
  logic [31:0]    step_count;
  logic           err;
  int             obstacle_cell = -1;
`ifdef LBM_BOUNCEBACK_EN
  logic           obstacle;
  logic [AW-1:0]  ra1, ra2;
`endif

  always #5 clk = ~clk;

  lbm_sequencer #(
    .HPIXELS(HP), .VPIXELS(VP), .DW(DW),
    .READ_LAT(RL), .COLL_LAT(CL), .WAIT_CYCLES(WC)
  ) dut (
    .clk_in(clk), .rst_n_in(rst_n),
    .run_in(run), .step_in(step), .restart_in(restart),
    .phase_out(phase),
    .setup_start_out(setup_start), .setup_done_in(setup_done),
    .setup_addr_in(setup_addr), .setup_data_in(setup_data), .setup_we_in(setup_we),
    .stream_start_out(stream_start), .stream_done_in(stream_done),
    .stream_addr_in(stream_addr), .stream_data_in(stream_data), .stream_we_in(stream_we),
    .rd_addr_out(rd_addr), .rd_data_in(rd_data),
`ifdef LBM_BOUNCEBACK_EN
    .obstacle_in(obstacle),
`endif
    .coll_valid_out(coll_valid_out), .coll_valid_in(coll_valid_in), .coll_data_in(coll_data),
    .wr_addr_out(wr_addr), .wr_data_out(wr_data), .wr_en_out(wr_en),
    .step_count_out(step_count), .err_out(err)
  );

  // Lattice BRAM model (bench-owned) and the reference lattice
  logic [CDW-1:0] mem     [DEPTH];
  logic [CDW-1:0] lattice [DEPTH];
  logic [CDW-1:0] rd_p1;
  logic           late;
  logic [CL:0]    cv;
  logic [CDW-1:0] cd [CL+1];
  int             checks = 0;
  int             errors = 0;
  int             exp_steps;

  function automatic logic [CDW-1:0] collide(input logic [CDW-1:0] c);
    logic [CDW-1:0] r;
    for (int q = 0; q < 9; q++) r[q*DW +: DW] = c[q*DW +: DW] + DW'(1);
    return r;
  endfunction

  // New slot s receives old slot src[s]: opposite-direction table for D2Q9.
  function automatic logic [CDW-1:0] reflect(input logic [CDW-1:0] c);
    logic [CDW-1:0] r;
    int src [9];
    src = '{0, 5, 6, 7, 8, 1, 2, 3, 4};
    for (int s = 0; s < 9; s++) r[s*DW +: DW] = c[src[s]*DW +: DW];
    return r;
  endfunction

  always @(posedge clk) begin
    rd_p1   <= mem[rd_addr];
    rd_data <= rd_p1;
    if (wr_en) mem[wr_addr] <= wr_data;
    cv[0] <= coll_valid_out;
    cd[0] <= collide(rd_data);
    for (int i = 1; i <= CL; i++) begin
      cv[i] <= cv[i-1];
      cd[i] <= cd[i-1];
    end
  end
  assign coll_valid_in = late ? cv[CL] : cv[CL-1];
  assign coll_data     = late ? cd[CL] : cd[CL-1];

`ifdef LBM_BOUNCEBACK_EN
  always @(posedge clk) begin
    ra1 <= rd_addr;
    ra2 <= ra1;
  end
  assign obstacle = (int'(ra2) == obstacle_cell);
`endif

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_phase(input logic [1:0] target, input int budget, input string tag);
    int n;
    n = 0;
    while (phase !== target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, 96'(phase === target), 96'd1);
  endtask

  task automatic pulse_step();
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
  endtask

  task automatic setup_fill(input bit pattern5);
    logic [CDW-1:0] d;
    for (int a = 0; a <= DEPTH; a++) begin
      if (a < DEPTH) begin
        d = CDW'({$urandom, $urandom, $urandom});
        if (pattern5 && a == 5) for (int q = 0; q < 9; q++) d[q*DW +: DW] = DW'(q);
        setup_addr = AW'(a);
        setup_data = d;
        setup_we   = 1'b1;
        lattice[a] = d;
      end else begin
        setup_we   = 1'b0;
        setup_done = 1'b1;
      end
      @(negedge clk);
      if (a < DEPTH) check("setup_mirror", 96'({wr_en, wr_addr, wr_data}), 96'({1'b1, AW'(a), d}));
    end
    setup_done = 1'b0;
    check("setup_to_waiting", 96'(phase), 96'd3);
    check("setup_wr_idle", 96'(wr_en), 96'd0);
  endtask

  task automatic timestep(input bit drop_run, input bit expect_err);
    int cyc, nwr, first_wr, bad_addr, bad_data, n, a;
    logic [CDW-1:0] d;
    logic [CDW-1:0] expd [DEPTH];
    for (int c = 0; c < DEPTH; c++)
      expd[c] = (c == obstacle_cell) ? reflect(lattice[c]) : collide(lattice[c]);
    wait_phase(2'd1, 64, "enter_collision");
    if (drop_run) run = 1'b0;
    cyc = 0; nwr = 0; first_wr = -1; bad_addr = 0; bad_data = 0;
    while (phase == 2'd1 && cyc < 200) begin
      if (wr_en) begin
        if (first_wr < 0) first_wr = cyc;
        if (int'(wr_addr) != nwr || cyc != first_wr + nwr) bad_addr++;
        else if (wr_data !== expd[nwr]) bad_data++;
        nwr++;
      end
      cyc++;
      @(negedge clk);
    end
    check("pass_len", 96'(cyc), 96'(PASS_LEN));
    check("write_count", 96'(nwr), 96'(DEPTH));
    check("first_write_cycle", 96'(first_wr), 96'(RL + CL + 1));
    check("write_order", 96'(bad_addr), 96'd0);
    if (!expect_err) check("write_data", 96'(bad_data), 96'd0);
    check("stream_start", 96'(stream_start), 96'd1);
    check("err_flag", 96'(err), 96'(expect_err));
    for (int c = 0; c < DEPTH; c++) lattice[c] = expd[c];
    // Streaming engine: a few random cell rewrites, then done.
    n = $urandom_range(1, 3);
    for (int k = 0; k <= n; k++) begin
      if (k < n) begin
        a = $urandom_range(0, DEPTH - 1);
        d = CDW'({$urandom, $urandom, $urandom});
        stream_addr = AW'(a);
        stream_data = d;
        stream_we   = 1'b1;
        lattice[a]  = d;
      end else begin
        stream_we   = 1'b0;
        stream_done = 1'b1;
      end
      @(negedge clk);
      if (k == 0) check("stream_start_pulse", 96'(stream_start), 96'd0);
      if (k < n) check("stream_mirror", 96'({wr_en, wr_addr, wr_data}), 96'({1'b1, AW'(a), d}));
    end
    stream_done = 1'b0;
    exp_steps++;
    check("stream_to_waiting", 96'(phase), 96'd3);
    check("step_count", 96'(step_count), 96'(exp_steps));
  endtask

  task automatic hold_check();
    int bad;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (phase != 2'd3) bad++;
    end
    check("hold_waiting", 96'(bad), 96'd0);
  endtask

  task automatic boot_check();
    int starts;
    starts = 0;
    repeat (4) begin
      @(negedge clk);
      starts += int'(setup_start);
    end
    check("boot_start_pulses", 96'(starts), 96'd1);
  endtask

  initial begin
    rst_n = 1'b0; run = 1'b0; step = 1'b0; restart = 1'b0;
    setup_done = 1'b0; setup_we = 1'b0; setup_addr = '0; setup_data = '0;
    stream_done = 1'b0; stream_we = 1'b0; stream_addr = '0; stream_data = '0;
    late = 1'b0; exp_steps = 0;
    repeat (3) @(negedge clk);
    check("rst_phase", 96'(phase), 96'd0);
    check("rst_wr_en", 96'(wr_en), 96'd0);
    check("rst_coll_valid", 96'(coll_valid_out), 96'd0);
    check("rst_err", 96'(err), 96'd0);
    check("rst_step_count", 96'(step_count), 96'd0);
    check("rst_pulses", 96'({setup_start, stream_start}), 96'd0);
    check("rst_addr", 96'({rd_addr, wr_addr, wr_data}), 96'd0);
    rst_n = 1'b1;
    boot_check();
    setup_fill(1'b0);

    // Free-run, with run dropped mid-pass: exactly one timestep
    run = 1'b1;
    timestep(1'b1, 1'b0);
    hold_check();
    check("run_drop_count", 96'(step_count), 96'd1);

    // Restart from WAITING
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    exp_steps = 0;
    check("restart_phase", 96'(phase), 96'd0);
    check("restart_start", 96'(setup_start), 96'd1);
    check("restart_count", 96'(step_count), 96'd0);
    @(negedge clk);
    check("restart_start_pulse", 96'(setup_start), 96'd0);
    setup_fill(1'b0);

    // Two step pulses while the wait counter runs: one timestep
    pulse_step();
    @(negedge clk);
    pulse_step();
    timestep(1'b0, 1'b0);
    hold_check();
    check("two_steps_count", 96'(step_count), 96'd1);

    // Back-to-back free-run timesteps
    run = 1'b1;
    for (int k = 0; k < 3; k++) timestep(k == 2, 1'b0);
    hold_check();

    // Late collider: sticky error
    late = 1'b1;
    pulse_step();
    timestep(1'b0, 1'b1);
    late = 1'b0;
    pulse_step();
    timestep(1'b0, 1'b1);

    // Reset in the middle of a collision pass
    pulse_step();
    wait_phase(2'd1, 64, "enter_collision_rst");
    repeat (7) @(negedge clk);
    check("pre_rst_wr_en", 96'(wr_en), 96'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_phase", 96'(phase), 96'd0);
    check("midrst_wr_en", 96'(wr_en), 96'd0);
    check("midrst_count", 96'(step_count), 96'd0);
    check("midrst_err", 96'(err), 96'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    exp_steps = 0;
    boot_check();
`ifdef LBM_BOUNCEBACK_EN
    obstacle_cell = 5;
`endif
    setup_fill(1'b1);
    pulse_step();
    timestep(1'b0, 1'b0);
    check("final_err", 96'(err), 96'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
